trace_capture_ctrl: RTL and testbench

Trigger-driven capture controller for the CPU retire trace: it watches the per-instruction trace bus (instruction, rd, rs1, rs2, imm, rd value) and stores a bounded window of records in an internal FIFO. Records drain to a shared debug sink over a valid/ready handshake. It sits between the pipeline writeback trace taps and the debug/console output path. It replaces free-running per-cycle printing with armed, triggered, lossless-or-flagged capture.

---
 rtl/trace_capture_ctrl_if.sv | 26 ++
 rtl/trace_capture_ctrl.sv | 136 +++++++++++++
 tb/tb_trace_capture_ctrl.sv | 283 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/trace_capture_ctrl_if.sv
// Retire-trace tap and record output handshake of the trace capture controller.
// master drives the trace bus and rec_ready; slave (the controller) drives rec_valid/rec_data.
interface trace_capture_ctrl_if;
    logic        trace_valid;
    logic [31:0] trace_instruction;
    logic [31:0] trace_rd_value;
    logic [11:0] trace_imm;
    logic [4:0]  trace_rd;
    logic [4:0]  trace_rs1;
    logic [4:0]  trace_rs2;
    logic        rec_valid;
    logic        rec_ready;
    logic [90:0] rec_data;

    modport master (
        output trace_valid, trace_instruction, trace_rd_value, trace_imm,
               trace_rd, trace_rs1, trace_rs2, rec_ready,
        input  rec_valid, rec_data
    );

    modport slave (
        input  trace_valid, trace_instruction, trace_rd_value, trace_imm,
               trace_rd, trace_rs1, trace_rs2, rec_ready,
        output rec_valid, rec_data
    );
endinterface

// File: rtl/trace_capture_ctrl.sv
// Armed/triggered capture of retire-trace records into a show-ahead FIFO drained over valid/ready.
// Write-to-valid latency 1 cycle; a full FIFO drops (and counts) records unless the sink pops that cycle.
module trace_capture_ctrl #(
    parameter int DEPTH       = 16,
    parameter int CAPTURE_LEN = 64,
    parameter int DROP_W      = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    trace_capture_ctrl_if.slave        tif,
    input  logic                       arm,
    input  logic                       abort,
    input  logic [31:0]                trig_mask,
    input  logic [31:0]                trig_value,
    output logic                       busy,
    output logic                       done,
    output logic                       overflow,
    output logic [DROP_W-1:0]          drop_count,
    output logic [$clog2(DEPTH+1)-1:0] fifo_level
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = $clog2(DEPTH+1);

    typedef enum logic [1:0] {IDLE, ARMED, CAPTURE, DRAIN} state_t;

    state_t        state, state_nxt;
    logic [90:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [LW-1:0] count;
    logic [15:0]   win_cnt, win_nxt;
    logic [90:0]   rec;
    logic          match, pop, push, drop, can_write, clr_stats, done_nxt;

    assign rec = {tif.trace_instruction, tif.trace_rd_value, tif.trace_imm,
                  tif.trace_rd, tif.trace_rs1, tif.trace_rs2};
    assign match     = tif.trace_valid && ((tif.trace_instruction & trig_mask) == (trig_value & trig_mask));
    assign pop       = (count != '0) && tif.rec_ready;
    // A full FIFO still accepts the record when the head leaves in the same cycle.
    assign can_write = (count != LW'(DEPTH)) || pop;

    always_comb begin
        state_nxt = state;
        win_nxt   = win_cnt;
        push      = 1'b0;
        drop      = 1'b0;
        clr_stats = 1'b0;
        done_nxt  = 1'b0;
        case (state)
            IDLE: begin
                if (arm) begin
                    state_nxt = ARMED;
                    clr_stats = 1'b1;
                    win_nxt   = '0;
                end
            end
            ARMED: begin
                if (match) begin
                    win_nxt   = 16'd1;
                    push      = can_write;
                    drop      = !can_write;
                    state_nxt = (16'd1 == 16'(CAPTURE_LEN)) ? DRAIN : CAPTURE;
                end
            end
            CAPTURE: begin
                if (tif.trace_valid) begin
                    win_nxt = win_cnt + 16'd1;
                    push    = can_write;
                    drop    = !can_write;
                    if (win_nxt == 16'(CAPTURE_LEN)) state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (count == '0) begin
                    state_nxt = IDLE;
                    done_nxt  = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
        // Abort wins over everything and leaves the drop statistics untouched.
        if (abort) begin
            state_nxt = IDLE;
            win_nxt   = win_cnt;
            push      = 1'b0;
            drop      = 1'b0;
            clr_stats = 1'b0;
            done_nxt  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            win_cnt    <= '0;
            done       <= 1'b0;
            overflow   <= 1'b0;
            drop_count <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
        end else begin
            state   <= state_nxt;
            win_cnt <= win_nxt;
            done    <= done_nxt;
            if (clr_stats) begin
                overflow   <= 1'b0;
                drop_count <= '0;
            end else if (drop) begin
                overflow <= 1'b1;
                if (drop_count != {DROP_W{1'b1}}) drop_count <= drop_count + DROP_W'(1);
            end
            if (abort) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
            end else begin
                if (push) wr_ptr <= wr_ptr + AW'(1);
                if (pop)  rd_ptr <= rd_ptr + AW'(1);
                case ({push, pop})
                    2'b10:   count <= count + LW'(1);
                    2'b01:   count <= count - LW'(1);
                    default: count <= count;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= rec;
    end

    assign tif.rec_valid = (count != '0);
    assign tif.rec_data  = (count != '0) ? mem[rd_ptr] : '0;
    assign busy          = (state != IDLE);
    assign fifo_level    = count;
endmodule

// File: tb/tb_trace_capture_ctrl.sv
// Bench for trace_capture_ctrl: two instances (window 4 and window 20) checked every cycle against a queue model.
module tb_trace_capture_ctrl;
    localparam int DEPTH = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, tv, arm4, arm20, abort_p, ready, sel;
    logic [31:0] instr, rdv, mask, value;
    logic [11:0] imm;
    logic [4:0]  rd, rs1, rs2;

    trace_capture_ctrl_if i4 ();
    trace_capture_ctrl_if i20 ();

    assign i4.trace_valid        = tv;
    assign i4.trace_instruction  = instr;
    assign i4.trace_rd_value     = rdv;
    assign i4.trace_imm          = imm;
    assign i4.trace_rd           = rd;
    assign i4.trace_rs1          = rs1;
    assign i4.trace_rs2          = rs2;
    assign i4.rec_ready          = ready;
    assign i20.trace_valid       = tv;
    assign i20.trace_instruction = instr;
    assign i20.trace_rd_value    = rdv;
    assign i20.trace_imm         = imm;
    assign i20.trace_rd          = rd;
    assign i20.trace_rs1         = rs1;
    assign i20.trace_rs2         = rs2;
    assign i20.rec_ready         = ready;

    logic        busy4, done4, ovf4, busy20, done20, ovf20;
    logic [15:0] drop4, drop20;
    logic [4:0]  lvl4, lvl20;

    trace_capture_ctrl #(.DEPTH(DEPTH), .CAPTURE_LEN(4), .DROP_W(16)) dut4 (
        .clk(clk), .rst_n(rst_n), .tif(i4), .arm(arm4), .abort(abort_p),
        .trig_mask(mask), .trig_value(value), .busy(busy4), .done(done4),
        .overflow(ovf4), .drop_count(drop4), .fifo_level(lvl4));

    trace_capture_ctrl #(.DEPTH(DEPTH), .CAPTURE_LEN(20), .DROP_W(16)) dut20 (
        .clk(clk), .rst_n(rst_n), .tif(i20), .arm(arm20), .abort(abort_p),
        .trig_mask(mask), .trig_value(value), .busy(busy20), .done(done20),
        .overflow(ovf20), .drop_count(drop20), .fifo_level(lvl20));

    logic        o_valid, o_busy, o_done, o_ovf;
    logic [90:0] o_data;
    logic [15:0] o_drop;
    logic [4:0]  o_lvl;

    always_comb begin
        if (sel) begin
            o_valid = i20.rec_valid; o_data = i20.rec_data; o_busy = busy20;
            o_done  = done20; o_ovf = ovf20; o_drop = drop20; o_lvl = lvl20;
        end else begin
            o_valid = i4.rec_valid; o_data = i4.rec_data; o_busy = busy4;
            o_done  = done4; o_ovf = ovf4; o_drop = drop4; o_lvl = lvl4;
        end
    end

    // Reference model: spec-level phase (0 idle, 1 armed, 2 capture, 3 drain) plus a record queue.
    int          ph, win, cap;
    bit          ovf_m [2];
    int          drops_m [2];
    bit          done_e;
    logic [90:0] q [$];
    logic [90:0] outq [$];
    int          n_cmp = 0, n_bad = 0, done_seen = 0;

    task automatic chk(input string tag, input logic [90:0] obs, input logic [90:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q.delete(); ph = 0; win = 0; done_e = 0;
        ovf_m[0] = 0; ovf_m[1] = 0; drops_m[0] = 0; drops_m[1] = 0;
    endtask

    task automatic model_edge();
        bit pop_m, push_m, room, arm_s;
        logic [90:0] r;
        if (!rst_n) return;
        r      = {instr, rdv, imm, rd, rs1, rs2};
        arm_s  = sel ? arm20 : arm4;
        cap    = sel ? 20 : 4;
        pop_m  = (q.size() > 0) && ready;
        push_m = 0;
        done_e = 0;
        if (abort_p) begin
            q.delete(); ph = 0;
            return;
        end
        room = (q.size() < DEPTH) || pop_m;
        case (ph)
            0: if (arm_s) begin ph = 1; ovf_m[sel] = 0; drops_m[sel] = 0; win = 0; end
            1: if (tv && ((instr & mask) == (value & mask))) begin
                   win = 1; push_m = 1; ph = (win == cap) ? 3 : 2;
               end
            2: if (tv) begin
                   win++;
                   if (room) push_m = 1;
                   else begin ovf_m[sel] = 1; if (drops_m[sel] < 65535) drops_m[sel]++; end
                   if (win == cap) ph = 3;
               end
            3: if (q.size() == 0) begin done_e = 1; ph = 0; end
            default: ph = 0;
        endcase
        if (pop_m) void'(q.pop_front());
        if (push_m) q.push_back(r);
    endtask

    task automatic check_all();
        chk("rec_valid",  91'(o_valid), 91'(q.size() > 0));
        chk("rec_data",   o_data, (q.size() > 0) ? q[0] : 91'd0);
        chk("fifo_level", 91'(o_lvl), 91'(q.size()));
        chk("busy",       91'(o_busy), 91'(ph != 0));
        chk("done",       91'(o_done), 91'(done_e));
        chk("overflow",   91'(o_ovf), 91'(ovf_m[sel]));
        chk("drop_count", 91'(o_drop), 91'(drops_m[sel]));
    endtask

    task automatic tick();
        if (o_valid && ready) outq.push_back(o_data);
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_all();
        if (o_done) done_seen++;
    endtask

    task automatic set_ret(input bit v, input logic [31:0] ins);
        tv = v; instr = ins; rdv = $urandom; imm = 12'($urandom);
        rd = 5'($urandom); rs1 = 5'($urandom); rs2 = 5'($urandom);
    endtask

    task automatic do_arm();
        if (sel) arm20 = 1'b1; else arm4 = 1'b1;
        tick();
        arm4 = 1'b0; arm20 = 1'b0;
    endtask

    task automatic run_until_idle(input int budget, input string tag);
        for (int c = 0; c < budget && (o_busy || o_valid); c++) tick();
        chk(tag, 91'(o_busy || o_valid), 91'(0));
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] ins1 [4];
        logic [6:0]  opcs [3];
        logic [90:0] held;
        logic [31:0] ins;
        ins1 = '{32'h00500093, 32'h00a00113, 32'h002081b3, 32'h00000013};
        opcs = '{7'h13, 7'h33, 7'h03};
        sel = 0; ready = 0; tv = 0; arm4 = 0; arm20 = 0; abort_p = 0;
        mask = 0; value = 0; instr = 0; rdv = 0; imm = 0; rd = 0; rs1 = 0; rs2 = 0;
        rst_n = 0;
        model_reset();
        #12;
        check_all();
        sel = 1; check_all();
        @(negedge clk); rst_n = 1;

        // Window of 4, trigger on first retire, sink always ready.
        sel = 0; mask = 0; ready = 1; outq.delete(); done_seen = 0;
        do_arm();
        for (int i = 0; i < 4; i++) begin set_ret(1, ins1[i]); tick(); end
        set_ret(0, 0);
        run_until_idle(20, "t1_idle");
        chk("t1_count", 91'(outq.size()), 91'(4));
        for (int i = 0; i < 4; i++)
            chk("t1_order", (i < outq.size()) ? 91'(outq[i][90:59]) : 91'(32'hdeadbeef), 91'(ins1[i]));
        chk("t1_done_once", 91'(done_seen), 91'(1));
        chk("t1_ovf", 91'(ovf4), 91'(0));

        // Exact-match trigger on the 5th of 10 instructions.
        mask = 32'hffffffff; value = 32'h002081b3; outq.delete();
        do_arm();
        for (int i = 0; i < 10; i++) begin
            ins = (i == 4) ? value : $urandom;
            if (i != 4 && ins == value) ins = ins ^ 32'h1;
            set_ret(1, ins); tick();
        end
        set_ret(0, 0);
        run_until_idle(20, "t2_idle");
        chk("t2_first", (outq.size() > 0) ? 91'(outq[0][90:59]) : 91'(0), 91'(value));
        chk("t2_count", 91'(outq.size()), 91'(4));

        // Window of 20 with a stalled sink: 16 stored, 4 dropped.
        sel = 1; mask = 0; ready = 0; outq.delete();
        do_arm();
        for (int i = 0; i < 20; i++) begin set_ret(1, $urandom); tick(); end
        set_ret(0, 0); tick();
        chk("t3_level", 91'(lvl20), 91'(16));
        chk("t3_ovf",   91'(ovf20), 91'(1));
        chk("t3_drops", 91'(drop20), 91'(4));
        ready = 1; done_seen = 0;
        run_until_idle(40, "t3_idle");
        chk("t3_out",  91'(outq.size()), 91'(16));
        chk("t3_done", 91'(done_seen), 91'(1));

        // Full FIFO with simultaneous push and pop, then a 1010 drain.
        ready = 0; outq.delete();
        do_arm();
        for (int i = 0; i < 16; i++) begin set_ret(1, $urandom); tick(); end
        chk("t4_full", 91'(lvl20), 91'(16));
        ready = 1; set_ret(1, $urandom); tick();
        chk("t4_level_kept", 91'(lvl20), 91'(16));
        chk("t4_no_drop",    91'(drop20), 91'(0));
        ready = 0;
        for (int i = 0; i < 3; i++) begin set_ret(1, $urandom); tick(); end
        set_ret(0, 0);
        for (int c = 0; c < 80 && (o_busy || o_valid); c++) begin
            ready = (c % 2 == 0);
            if (!ready && o_valid) begin
                held = o_data;
                tick();
                chk("t5_hold", o_data, held);
            end else tick();
        end
        chk("t5_idle",  91'(o_busy || o_valid), 91'(0));
        chk("t5_out",   91'(outq.size()), 91'(17));
        chk("t5_drops", 91'(drop20), 91'(3));

        // Abort mid-capture at level 7.
        ready = 0; done_seen = 0;
        do_arm();
        for (int i = 0; i < 7; i++) begin set_ret(1, $urandom); tick(); end
        chk("t6_level7", 91'(lvl20), 91'(7));
        abort_p = 1; set_ret(1, $urandom); tick();
        abort_p = 0; set_ret(0, 0);
        chk("t6_busy",  91'(busy20), 91'(0));
        chk("t6_valid", 91'(i20.rec_valid), 91'(0));
        chk("t6_level", 91'(lvl20), 91'(0));
        for (int i = 0; i < 3; i++) tick();
        chk("t6_no_done", 91'(done_seen), 91'(0));

        // Randomized rounds on both instances.
        for (int r = 0; r < 8; r++) begin
            sel = 1'($urandom % 2);
            mask = ($urandom % 2 == 0) ? 32'h0 : 32'h7f;
            value = {25'($urandom), opcs[$urandom % 3]};
            do_arm();
            for (int c = 0; c < 100; c++) begin
                set_ret($urandom % 4 != 0, {25'($urandom), opcs[$urandom % 3]});
                ready = 1'($urandom % 2);
                abort_p = ($urandom % 150 == 0);
                if ($urandom % 30 == 0) begin if (sel) arm20 = 1; else arm4 = 1; end
                tick();
                abort_p = 0; arm4 = 0; arm20 = 0;
            end
            set_ret(0, 0); ready = 1;
            for (int c = 0; c < 20; c++) tick();
            abort_p = 1; tick(); abort_p = 0;
        end

        // Reset pulsed mid-drain.
        sel = 1; mask = 0; ready = 0;
        do_arm();
        for (int i = 0; i < 20; i++) begin set_ret(1, $urandom); tick(); end
        set_ret(0, 0); tick();
        chk("t8_in_drain", 91'(lvl20), 91'(16));
        #2 rst_n = 0;
        #1 model_reset();
        check_all();
        tick();
        rst_n = 1;
        for (int i = 0; i < 2; i++) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
